// File: rtl/ierdna_arb.sv
// Round-robin arbiter sharing one resource among aral/atac/ide/icul with a dead gap per hand-over.
// Optional tenure limit and preempt pulse compiled in with `define IERDNA_ARB_TIMEOUT_EN.
module ierdna_arb #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;
    logic       win_vld_c;
    logic [1:0] win_idx_c;

    // Elaboration-time sanity check of the tenure parameters.
    if (HOLD_MAX < 1 || ((1 << CNT_W) - 1) < HOLD_MAX) begin : g_bad_cfg
        $error("ierdna_arb: HOLD_MAX must be >= 1 and fit in CNT_W bits");
    end

`ifdef IERDNA_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] ten_q, ten_d;
    logic             preempt_q, preempt_d;
    logic             timeout_c;

    assign timeout_c = (ten_q == CNT_W'(HOLD_MAX));
`endif

    // Rotating search: descending offsets so the one closest to ptr is written last and wins.
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                win_vld_c = 1'b1;
                win_idx_c = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
`ifdef IERDNA_ARB_TIMEOUT_EN
        ten_d     = ten_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_GAP: begin
                if (win_vld_c) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << win_idx_c;
                    owner_d = win_idx_c;
`ifdef IERDNA_ARB_TIMEOUT_EN
                    ten_d   = CNT_W'(1);
`endif
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            S_GRANT: begin
`ifdef IERDNA_ARB_TIMEOUT_EN
                if (ten_q != {CNT_W{1'b1}}) begin
                    ten_d = ten_q + CNT_W'(1);
                end
`endif
                if (!req[owner_q]) begin
                    state_d = S_GAP;
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                end
`ifdef IERDNA_ARB_TIMEOUT_EN
                // A release on the same edge takes precedence, so no preempt then.
                else if (timeout_c) begin
                    state_d   = S_GAP;
                    gnt_d     = 4'b0000;
                    ptr_d     = owner_q + 2'd1;
                    preempt_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

`ifdef IERDNA_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ten_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            ten_q     <= ten_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule
